// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (CPU / debug loader) arbiter for a synchronous single-port memory
// Round-robin grant with debug lock; one access in flight, outputs registered.
module mem_arbiter #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [A_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_wdata,
  input  logic               dbg_req,
  input  logic               dbg_wr,
  input  logic [A_WIDTH-1:0] dbg_addr,
  input  logic [D_WIDTH-1:0] dbg_wdata,
  input  logic               dbg_lock,
  output logic               cpu_gnt,
  output logic               dbg_gnt,
  output logic               cpu_rvalid,
  output logic               dbg_rvalid,
  output logic [D_WIDTH-1:0] cpu_rdata,
  output logic [D_WIDTH-1:0] dbg_rdata,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic               mem_data_oe,
  input  logic [D_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t             state_q;
  logic               owner_dbg_q;
  logic               last_dbg_q;
  logic               cpu_gnt_q;
  logic               dbg_gnt_q;
  logic               cpu_rvalid_q;
  logic               dbg_rvalid_q;
  logic               mem_rd_q;
  logic               mem_wr_q;
  logic               mem_data_oe_q;
  logic [A_WIDTH-1:0] mem_addr_q;
  logic [D_WIDTH-1:0] mem_wdata_q;

  logic               cpu_elig_d;
  logic               any_req_d;
  logic               win_dbg_d;
  logic               win_wr_d;
  logic [A_WIDTH-1:0] win_addr_d;
  logic [D_WIDTH-1:0] win_wdata_d;

  // Debug wins a tie only when the CPU was granted most recently.
  always_comb begin
    cpu_elig_d  = cpu_req & ~dbg_lock;
    any_req_d   = cpu_elig_d | dbg_req;
    win_dbg_d   = dbg_req & (~cpu_elig_d | ~last_dbg_q);
    win_wr_d    = win_dbg_d ? dbg_wr    : cpu_wr;
    win_addr_d  = win_dbg_d ? dbg_addr  : cpu_addr;
    win_wdata_d = win_dbg_d ? dbg_wdata : cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_dbg_q   <= 1'b0;
      last_dbg_q    <= 1'b1;
      cpu_gnt_q     <= 1'b0;
      dbg_gnt_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_data_oe_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      cpu_gnt_q     <= 1'b0;
      dbg_gnt_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_data_oe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            owner_dbg_q   <= win_dbg_d;
            last_dbg_q    <= win_dbg_d;
            cpu_gnt_q     <= ~win_dbg_d;
            dbg_gnt_q     <= win_dbg_d;
            mem_addr_q    <= win_addr_d;
            mem_wdata_q   <= win_wdata_d;
            mem_wr_q      <= win_wr_d;
            mem_data_oe_q <= win_wr_d;
            mem_rd_q      <= ~win_wr_d;
            state_q       <= ACC;
          end
        end
        ACC: begin
          // mem_wr_q still holds the latched direction of the access in flight.
          if (mem_wr_q) begin
            state_q <= IDLE;
          end else begin
            cpu_rvalid_q <= ~owner_dbg_q;
            dbg_rvalid_q <= owner_dbg_q;
            state_q      <= RDATA;
          end
        end
        RDATA: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_gnt     = cpu_gnt_q;
  assign dbg_gnt     = dbg_gnt_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_data_oe = mem_data_oe_q;

  // The synchronous memory presents read data during RDATA; gate it so only the owner sees it.
  assign cpu_rdata = cpu_rvalid_q ? mem_rdata : '0;
  assign dbg_rdata = dbg_rvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and random self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_req, cpu_wr, dbg_req, dbg_wr, dbg_lock;
  logic [4:0] cpu_addr, dbg_addr;
  logic [7:0] cpu_wdata, dbg_wdata;
  logic       cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
  logic [7:0] cpu_rdata, dbg_rdata;
  logic       mem_rd, mem_wr, mem_data_oe;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] mem_m [32];
  logic [7:0] sb [32];
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.A_WIDTH(5), .D_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock),
    .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid),
    .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_oe(mem_data_oe), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem_m[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem_m[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) chk("rd_wr_excl", 32'(mem_rd & mem_wr), 0);

  task automatic access(input bit d, input bit wr, input logic [4:0] addr,
                        input logic [7:0] wd, input bit scramble, output int lat);
    bit got;
    got = 0;
    lat = 0;
    if (d) begin dbg_req = 1; dbg_wr = wr; dbg_addr = addr; dbg_wdata = wd; end
    else   begin cpu_req = 1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd; end
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (d ? dbg_gnt : cpu_gnt) got = 1;
    end
    chk("gnt_seen", 32'(got), 1);
    if (d) dbg_req = 0; else cpu_req = 0;
    if (got) begin
      if (scramble) begin
        if (d) begin dbg_addr = ~addr; dbg_wdata = ~wd; end
        else   begin cpu_addr = ~addr; cpu_wdata = ~wd; end
        #1;
      end
      chk("acc_addr", 32'(mem_addr), 32'(addr));
      chk("acc_wr", 32'(mem_wr), 32'(wr));
      chk("acc_rd", 32'(mem_rd), 32'(!wr));
      chk("acc_oe", 32'(mem_data_oe), 32'(wr));
      if (wr) chk("acc_wdata", 32'(mem_wdata), 32'(wd));
      chk("gnt_other", 32'(d ? cpu_gnt : dbg_gnt), 0);
      @(negedge clk);
      chk("gnt_pulse", 32'(cpu_gnt | dbg_gnt), 0);
      chk("strobe_off", 32'(mem_wr | mem_rd | mem_data_oe), 0);
      if (wr) begin
        sb[addr] = wd;
        chk("wr_no_rv", 32'(cpu_rvalid | dbg_rvalid), 0);
      end else begin
        chk("rv_own", 32'(d ? dbg_rvalid : cpu_rvalid), 1);
        chk("rv_other", 32'(d ? cpu_rvalid : dbg_rvalid), 0);
        chk("rdata", 32'(d ? dbg_rdata : cpu_rdata), 32'(sb[addr]));
      end
    end
  endtask

  initial begin
    int lat, n, gcpu, gdbg;
    bit got, exp_dbg;
    rst = 0; cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'({cpu_gnt, dbg_gnt}), 0);
    chk("rst_rv", 32'({cpu_rvalid, dbg_rvalid}), 0);
    chk("rst_strobes", 32'({mem_rd, mem_wr, mem_data_oe}), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'({cpu_rdata, dbg_rdata}), 0);
    rst = 1;

    // CPU write then debug read-back of the same location
    access(0, 1, 5'd5, 8'hA5, 0, lat);
    chk("w_lat", 32'(lat), 1);
    access(1, 0, 5'd5, 8'h00, 0, lat);
    chk("r_lat", 32'(lat), 1);
    chk("r_back", 32'(dbg_rdata), 32'hA5);

    for (int a = 0; a < 32; a++) access(a[0], 1, 5'(a), 8'(a * 7 + 3), 0, lat);

    // Tie from reset: CPU first, then strict alternation
    rst = 0;
    @(negedge clk);
    rst = 1;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 5'd1;
    dbg_req = 1; dbg_wr = 0; dbg_addr = 5'd2;
    exp_dbg = 0;
    for (int i = 0; i < 4; i++) begin
      got = 0; n = 0;
      while (!got && n < 10) begin
        @(negedge clk); n++;
        if (cpu_gnt | dbg_gnt) got = 1;
      end
      chk("rr_gnt_seen", 32'(got), 1);
      if (i == 0) chk("rr_first_lat", 32'(n), 1);
      chk("rr_order", 32'(dbg_gnt), 32'(exp_dbg));
      chk("rr_one_gnt", 32'(cpu_gnt & dbg_gnt), 0);
      @(negedge clk);
      chk("rr_rv_cpu", 32'(cpu_rvalid), 32'(!exp_dbg));
      chk("rr_rv_dbg", 32'(dbg_rvalid), 32'(exp_dbg));
      chk("rr_rdata", 32'(exp_dbg ? dbg_rdata : cpu_rdata), 32'(exp_dbg ? sb[2] : sb[1]));
      exp_dbg = !exp_dbg;
    end
    cpu_req = 0; dbg_req = 0;
    @(negedge clk);

    // Lock holds off the CPU while debug keeps reading
    dbg_lock = 1;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 5'd3;
    dbg_req = 1; dbg_wr = 0; dbg_addr = 5'd4;
    gcpu = 0; gdbg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gcpu += int'(cpu_gnt);
      gdbg += int'(dbg_gnt);
    end
    chk("lock_no_cpu", 32'(gcpu), 0);
    chk("lock_dbg_prog", 32'(gdbg >= 6), 1);
    dbg_req = 0; dbg_lock = 0;
    got = 0; n = 0;
    while (!got && n < 6) begin
      @(negedge clk); n++;
      if (cpu_gnt) got = 1;
    end
    chk("unlock_cpu_gnt", 32'(got), 1);
    cpu_req = 0;
    @(negedge clk);
    chk("unlock_rv", 32'(cpu_rvalid), 1);
    chk("unlock_rdata", 32'(cpu_rdata), 32'(sb[3]));

    // Lock rising during a CPU read does not abort it
    @(negedge clk);
    cpu_req = 1; cpu_addr = 5'd6;
    got = 0; n = 0;
    while (!got && n < 6) begin
      @(negedge clk); n++;
      if (cpu_gnt) got = 1;
    end
    chk("late_lock_gnt", 32'(got), 1);
    cpu_req = 0; dbg_lock = 1;
    @(negedge clk);
    chk("late_lock_rv", 32'(cpu_rvalid), 1);
    chk("late_lock_rdata", 32'(cpu_rdata), 32'(sb[6]));
    dbg_lock = 0;
    @(negedge clk);

    // Reset in the middle of a read access
    cpu_req = 1; cpu_wr = 0; cpu_addr = 5'd31;
    got = 0; n = 0;
    while (!got && n < 6) begin
      @(negedge clk); n++;
      if (cpu_gnt) got = 1;
    end
    chk("mid_rst_gnt", 32'(got), 1);
    chk("mid_rst_rd_before", 32'(mem_rd), 1);
    cpu_req = 0;
    #2 rst = 0;
    #1;
    chk("mid_rst_strobes", 32'({mem_rd, mem_wr, mem_data_oe}), 0);
    chk("mid_rst_gnt0", 32'({cpu_gnt, dbg_gnt}), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rv", 32'({cpu_rvalid, dbg_rvalid}), 0);
      chk("mid_rst_no_rd", 32'(mem_rd), 0);
    end
    rst = 1;
    access(0, 0, 5'd31, 8'h00, 0, lat);
    chk("post_rst_lat", 32'(lat), 1);

    // Inputs changed during ACC must not leak into memory
    access(0, 1, 5'd7, 8'h5A, 1, lat);
    access(1, 1, 5'd9, 8'hC3, 1, lat);
    access(1, 0, 5'd7, 8'h00, 0, lat);
    access(0, 0, 5'd24, 8'h00, 0, lat);
    access(0, 0, 5'd9, 8'h00, 0, lat);

    for (int i = 0; i < 40; i++)
      access(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), 0, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
